// File: rtl/fpu_issue_scheduler.sv
// Issue controller for the FPU: routes ops to the pipelined path or the iterative div/sqrt unit
// and reserves the shared writeback slot so that only one result retires per cycle.
module fpu_issue_scheduler #(
  parameter int PIPE_LATENCY = 4,
  parameter int DIV_CYCLES   = 26,
  parameter int TAG_WIDTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 req_valid,
  input  logic [2:0]           req_op,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 req_ready,
  output logic                 issue_pipe,
  output logic                 div_start,
  output logic                 div_step,
  output logic                 div_busy,
  output logic                 wb_valid,
  output logic [TAG_WIDTH-1:0] wb_tag,
  output logic                 wb_from_div,
  output logic                 wb_illegal,
  output logic [5:0]           in_flight,
  output logic                 idle
);

  localparam int CW = $clog2(DIV_CYCLES);

  typedef enum logic {D_IDLE = 1'b0, D_BUSY = 1'b1} dstate_t;

  dstate_t                state, state_next;
  logic [CW-1:0]          cnt;
  logic [DIV_CYCLES-1:0]  resv, resv_next;
  logic [TAG_WIDTH-1:0]   div_tag;
  logic [PIPE_LATENCY-1:0] tp_vld, tp_ill;
  logic [TAG_WIDTH-1:0]   tp_tag [PIPE_LATENCY];
  logic clear, is_div, is_illegal, hs, pipe_hs, retire, tail_vld;

  assign clear      = reset | flush;
  assign is_div     = (req_op == 3'd3) || (req_op == 3'd4);
  assign is_illegal = req_op[2] & (|req_op[1:0]);

  // resv[PIPE_LATENCY] is the slot a new pipelined op would occupy once the vector shifts
  always_comb begin
    req_ready = 1'b0;
    if (!clear) begin
      if (is_div) req_ready = (state == D_IDLE);
      else        req_ready = !resv[PIPE_LATENCY];
    end
  end

  assign hs         = req_valid & req_ready;
  assign pipe_hs    = hs & !is_div;
  assign issue_pipe = pipe_hs & !is_illegal;
  assign div_start  = hs & is_div;

  always_comb begin
    resv_next = {1'b0, resv[DIV_CYCLES-1:1]};
    if (pipe_hs)   resv_next[PIPE_LATENCY-1] = 1'b1;
    if (div_start) resv_next[DIV_CYCLES-1]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clear) resv <= '0;
    else       resv <= resv_next;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      tp_vld <= '0;
      tp_ill <= '0;
      for (int i = 0; i < PIPE_LATENCY; i++) tp_tag[i] <= '0;
    end else begin
      tp_vld[0] <= pipe_hs;
      tp_ill[0] <= is_illegal;
      tp_tag[0] <= req_tag;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        tp_vld[i] <= tp_vld[i-1];
        tp_ill[i] <= tp_ill[i-1];
        tp_tag[i] <= tp_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear)          div_tag <= '0;
    else if (div_start) div_tag <= req_tag;
  end

  // A retiring slot not claimed by the pipe tail must belong to the iterative unit
  assign retire      = resv[0] & !clear;
  assign tail_vld    = tp_vld[PIPE_LATENCY-1];
  assign wb_valid    = retire;
  assign wb_from_div = retire & !tail_vld;
  assign wb_illegal  = retire & tail_vld & tp_ill[PIPE_LATENCY-1];
  assign wb_tag      = !retire ? '0 : (tail_vld ? tp_tag[PIPE_LATENCY-1] : div_tag);

  always_ff @(posedge clk) begin
    if (clear) state <= D_IDLE;
    else       state <= state_next;
  end

  // Busy lasts DIV_CYCLES-1 cycles so the FSM is idle again in the retire cycle
  always_comb begin
    state_next = state;
    case (state)
      D_IDLE: if (div_start) state_next = D_BUSY;
      D_BUSY: if (cnt == CW'(1)) state_next = D_IDLE;
      default: state_next = D_IDLE;
    endcase
  end

  always_comb begin
    div_busy = (state == D_BUSY);
    div_step = (state == D_BUSY);
  end

  always_ff @(posedge clk) begin
    if (clear)              cnt <= '0;
    else if (div_start)     cnt <= CW'(DIV_CYCLES - 1);
    else if (state == D_BUSY) cnt <= cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (clear) in_flight <= '0;
    else begin
      case ({hs, retire})
        2'b10:   in_flight <= in_flight + 6'd1;
        2'b01:   in_flight <= in_flight - 6'd1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  assign idle = !reset && (in_flight == 6'd0) && (state == D_IDLE);

endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// Randomized plus directed bench for fpu_issue_scheduler with a cycle-level reference model
// and a retire-order scoreboard.
module tb_fpu_issue_scheduler;
  localparam int P  = 4;
  localparam int D  = 26;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset, flush, req_valid;
  logic [2:0]    req_op;
  logic [TW-1:0] req_tag;
  logic          req_ready, issue_pipe, div_start, div_step, div_busy;
  logic          wb_valid, wb_from_div, wb_illegal, idle;
  logic [TW-1:0] wb_tag;
  logic [5:0]    in_flight;

  fpu_issue_scheduler #(.PIPE_LATENCY(P), .DIV_CYCLES(D), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_op(req_op),
    .req_tag(req_tag), .req_ready(req_ready), .issue_pipe(issue_pipe), .div_start(div_start),
    .div_step(div_step), .div_busy(div_busy), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .wb_from_div(wb_from_div), .wb_illegal(wb_illegal), .in_flight(in_flight), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [TW-1:0] tag;
    logic          from_div;
    logic          ill;
  } exp_t;

  exp_t exp_q[$];
  int   retire_at[$];
  int   div_s   = -1000;
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;
  bit   started = 0;
  exp_t e_mon;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, want);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT retires a result
  always @(negedge clk) begin
    if (started) begin
      if (reset || flush) begin
        chk("wb_quiet", wb_valid, 0);
      end else if (wb_valid) begin
        if (exp_q.size() == 0) chk("wb_unexpected", 1, 0);
        else begin
          e_mon = exp_q.pop_front();
          chk("wb_cycle", cyc, e_mon.cyc);
          chk("wb_tag", wb_tag, e_mon.tag);
          chk("wb_from_div", wb_from_div, e_mon.from_div);
          chk("wb_illegal", wb_illegal, e_mon.ill);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        chk("wb_missing", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // Reference model: slot occupancy as a list of retire cycles, div unit as its start cycle
  always @(negedge clk) begin
    #1;
    if (started) begin
      bit   exp_busy, exp_ready, hs, div_op, taken;
      int   rc, idx;
      exp_t e;
      for (int i = retire_at.size() - 1; i >= 0; i--)
        if (retire_at[i] < cyc) retire_at.delete(i);
      exp_busy = (cyc > div_s) && (cyc < div_s + D);
      chk("in_flight", in_flight, retire_at.size());
      chk("div_busy", div_busy, exp_busy);
      chk("div_step", div_step, exp_busy);
      chk("idle", idle, (!reset && retire_at.size() == 0 && !exp_busy));
      div_op = (req_op == 3) || (req_op == 4);
      taken = 0;
      foreach (retire_at[i]) if (retire_at[i] == cyc + P) taken = 1;
      if (reset || flush) exp_ready = 0;
      else if (div_op)    exp_ready = (cyc >= div_s + D);
      else                exp_ready = !taken;
      chk("req_ready", req_ready, exp_ready);
      hs = req_valid && exp_ready;
      chk("issue_pipe", issue_pipe, hs && req_op <= 2);
      chk("div_start", div_start, hs && div_op);
      if (reset || flush) begin
        retire_at.delete();
        exp_q.delete();
        div_s = -1000;
      end else if (hs) begin
        rc = div_op ? cyc + D : cyc + P;
        if (div_op) div_s = cyc;
        retire_at.push_back(rc);
        e.cyc = rc; e.tag = req_tag; e.from_div = div_op; e.ill = (req_op >= 5);
        idx = exp_q.size();
        for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].cyc > rc) idx = i;
        exp_q.insert(idx, e);
      end
    end
  end

  task automatic drive(input bit v, input int op, input int tag, input bit fl, input bit rs);
    req_valid = v;
    req_op    = 3'(op);
    req_tag   = TW'(tag);
    flush     = fl;
    reset     = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_for(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; flush = 0; req_valid = 0; req_op = 0; req_tag = 0;
    @(posedge clk);
    #1;
    started = 1;
    drive(0, 0, 0, 0, 1);
    // single add, tag 3
    drive(1, 0, 3, 0, 0);
    idle_for(6);
    // back-to-back muls
    for (int i = 1; i <= 4; i++) drive(1, 2, i, 0, 0);
    idle_for(6);
    // div then adds offered every cycle, including the collision cycle
    drive(1, 3, 9, 0, 0);
    for (int i = 0; i < 30; i++) drive(1, 0, 5, 0, 0);
    idle_for(6);
    // second div offered while the first is busy
    drive(1, 3, 1, 0, 0);
    for (int i = 0; i < 30; i++) drive(1, 4, 2, 0, 0);
    idle_for(30);
    // illegal opcode
    drive(1, 6, 2, 0, 0);
    idle_for(6);
    // flush with a div and an add in flight, request presented during flush
    drive(1, 3, 7, 0, 0);
    drive(1, 1, 8, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 11, 1, 0);
    drive(1, 0, 10, 0, 0);
    idle_for(45);
    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 15),
            $urandom_range(0, 99) == 0, $urandom_range(0, 499) == 0);
    end
    idle_for(60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
